csr_trap_ctrl: RTL and testbench
================================

// Module: csr_trap_ctrl
// PURPOSE
//  Multi-cycle CSR/trap sequencer between the execute stage and the CSR register file.
//  Accepts one CSR or trap instruction per handshake and performs CSRRW/CSRRS/CSRRC
//  read-modify-write, ECALL (mepc/mcause update) and MRET.
//  Drives the CSR file's address/data/type inputs.
//  Returns the old CSR value for rd and a PC redirect (mtvec or mepc) to fetch.
// PARAMETERS
//  DATA_WIDTH   32      datapath width
//  TYPE_WRITE   3'b001  csr_type_o code: write csr_wdata_o to csr_addr_o (odd parity)
//  TYPE_ECALL   3'b110  csr_type_o code: write mepc/mcause (even parity, nonzero)
//  ECALL_CAUSE  32'd11  mcause value for ECALL from M-mode
// PORTS
//  clock         in   1   clock
//  reset         in   1   synchronous, active-high
//  in_valid      in   1   request valid
//  in_ready      out  1   block can accept (IDLE only)
//  in_op         in   3   001 CSRRW, 010 CSRRS, 011 CSRRC, 100 ECALL, 101 MRET; others illegal
//  in_pc         in   32  PC of the instruction
//  in_csr_addr   in   12  CSR address
//  in_src        in   32  rs1 value or zero-extended uimm
//  in_src_zero   in   1   rs1 index / uimm is zero (suppresses write for CSRRS/CSRRC)
//  csr_addr_o    out  12  address to CSR file
//  csr_wdata_o   out  32  write data to CSR file
//  csr_type_o    out  3   0 idle, TYPE_WRITE, TYPE_ECALL
//  csr_mepc_o    out  32  mepc value for ECALL
//  csr_mcause_o  out  32  mcause value for ECALL
//  csr_rdata_i   in   32  combinational read of csr_addr_o
//  csr_mtvec_i   in   32  current mtvec
//  csr_mepc_i    in   32  current mepc
//  out_valid     out  1   result valid; held until out_ready
//  out_ready     in   1   consumer accepts result
//  out_rd_data   out  32  old CSR value (CSR ops), else 0
//  out_rd_wen    out  1   rd write enable (CSR ops only)
//  redirect_en   out  1   redirect valid, qualified by out_valid
//  redirect_pc   out  32  target PC (mtvec for ECALL, mepc for MRET)
// BEHAVIOUR
//  - States: IDLE, READ, WRITE, TRAP, RESP. in_ready=1 only in IDLE.
//  - Handshake in_valid&in_ready at edge T: latch op/pc/addr/src/src_zero; later input changes ignored.
//  - IDLE->READ (CSR ops), ->TRAP (ECALL), ->RESP (MRET, illegal).
//  - READ (T+1): csr_addr_o=latched addr; csr_rdata_i captured into old at end of cycle.
//  - WRITE (T+2): csr_type_o=TYPE_WRITE. Data: RW src; RS old|src; RC old&~src.
//    RS/RC with src_zero: csr_type_o=0 (no write); state and timing unchanged.
//  - TRAP (T+1): csr_type_o=TYPE_ECALL, csr_mepc_o=pc, csr_mcause_o=ECALL_CAUSE; capture csr_mtvec_i.
//  - RESP: out_valid=1. Entered at T+3 (CSR ops), T+2 (ECALL), T+1 (MRET, illegal).
//    Outputs stable until out_valid&out_ready, then ->IDLE; next accept no earlier than the following edge.
//  - RESP fields: CSR ops rd_wen=1, rd_data=old. ECALL redirect_en=1, redirect_pc=captured mtvec.
//    MRET redirect_en=1, redirect_pc=csr_mepc_i sampled on entry to RESP. Illegal: all result fields 0.
//  - csr_type_o nonzero for exactly one cycle per write; 0 in all other states.
//  - Reset (any state, incl. mid-WRITE/TRAP): state=IDLE; csr_type_o=0 that cycle; in-flight op dropped.
//    All outputs reset to 0; in_ready=1 from the first cycle after reset deasserts.
//  - No arithmetic wraps; widths exact; csr_addr_o/csr_wdata_o hold last value when idle.
// TESTING
//  1. CSRRW addr 0x305 src 0x8000_0100, old 0x0 -> WRITE cycle type=001 wdata 0x8000_0100; out_valid at T+3, rd_data 0x0.
//  2. CSRRS 0x300 old 0x1800 src 0x8 -> wdata 0x1808. Then CSRRC src 0x1000 -> wdata 0x0808. rd_data 0x1800, then 0x1808.
//  3. CSRRS src_zero=1 on 0xF11 -> csr_type_o never nonzero; rd_data 0x79737978.
//  4. ECALL pc 0x8000_0040, mtvec 0x8000_1000 -> TRAP: type=110, mepc 0x8000_0040, mcause 11; redirect_pc 0x8000_1000 at T+2.
//  5. MRET with mepc 0x8000_0044, out_ready low 5 cycles -> out_valid/redirect_pc held stable; in_ready=0 until accept.
//  6. Reset asserted during WRITE -> csr_type_o=0 that cycle; IDLE, all outputs 0; new CSRRW completes normally.

Source files
------------

// File: rtl/csr_trap_ctrl.sv
// csr_trap_ctrl
//   Multi-cycle CSR/trap sequencer sitting between execute and the CSR file.
//   Accepts one CSRRW/CSRRS/CSRRC/ECALL/MRET per handshake, performs the CSR
//   read-modify-write or trap update, then returns the old CSR value for rd
//   and/or a PC redirect (mtvec for ECALL, mepc for MRET).
// Ports
//   clock, reset                 clock; synchronous active-high reset
//   in_valid/in_ready            request handshake (ready only when idle)
//   in_op/in_pc/in_csr_addr      operation, instruction PC, CSR address
//   in_src/in_src_zero           rs1/uimm operand and its "index is zero" flag
//   csr_addr_o/csr_wdata_o       CSR file address and write data (held when idle)
//   csr_type_o                   0 idle, TYPE_WRITE, TYPE_ECALL (one cycle per write)
//   csr_mepc_o/csr_mcause_o      trap values written on ECALL
//   csr_rdata_i                  combinational read of csr_addr_o
//   csr_mtvec_i/csr_mepc_i       current mtvec / mepc
//   out_valid/out_ready          result handshake, result held until accepted
//   out_rd_data/out_rd_wen       old CSR value and rd write enable (CSR ops)
//   redirect_en/redirect_pc      fetch redirect, qualified by out_valid
module csr_trap_ctrl #(
  parameter int unsigned                DATA_WIDTH  = 32,
  parameter logic [2:0]                 TYPE_WRITE  = 3'b001,
  parameter logic [2:0]                 TYPE_ECALL  = 3'b110,
  parameter logic [DATA_WIDTH-1:0]      ECALL_CAUSE = DATA_WIDTH'(11)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_op,
  input  logic [DATA_WIDTH-1:0] in_pc,
  input  logic [11:0]           in_csr_addr,
  input  logic [DATA_WIDTH-1:0] in_src,
  input  logic                  in_src_zero,
  output logic [11:0]           csr_addr_o,
  output logic [DATA_WIDTH-1:0] csr_wdata_o,
  output logic [2:0]            csr_type_o,
  output logic [DATA_WIDTH-1:0] csr_mepc_o,
  output logic [DATA_WIDTH-1:0] csr_mcause_o,
  input  logic [DATA_WIDTH-1:0] csr_rdata_i,
  input  logic [DATA_WIDTH-1:0] csr_mtvec_i,
  input  logic [DATA_WIDTH-1:0] csr_mepc_i,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_rd_data,
  output logic                  out_rd_wen,
  output logic                  redirect_en,
  output logic [DATA_WIDTH-1:0] redirect_pc
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_TRAP,
    S_RESP
  } state_e;

  typedef enum logic [2:0] {
    OP_CSRRW = 3'b001,
    OP_CSRRS = 3'b010,
    OP_CSRRC = 3'b011,
    OP_ECALL = 3'b100,
    OP_MRET  = 3'b101
  } op_e;

  state_e                state_q, state_d;
  logic [2:0]            op_q, op_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [11:0]           addr_q, addr_d;
  logic [DATA_WIDTH-1:0] src_q, src_d;
  logic                  src_zero_q, src_zero_d;
  logic [DATA_WIDTH-1:0] old_q, old_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] redir_pc_q, redir_pc_d;

  logic                  run;
  logic                  is_csr_op;
  logic                  is_redir_op;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] new_val;

  assign is_csr_op   = (op_q == OP_CSRRW) || (op_q == OP_CSRRS) || (op_q == OP_CSRRC);
  assign is_redir_op = (op_q == OP_ECALL) || (op_q == OP_MRET);
  // CSRRS/CSRRC with a zero source must not write (no side effects on the CSR).
  assign wr_en       = (op_q == OP_CSRRW) || !src_zero_q;

  always_comb begin
    new_val = src_q;
    case (op_q)
      OP_CSRRS: new_val = csr_rdata_i | src_q;
      OP_CSRRC: new_val = csr_rdata_i & ~src_q;
      default:  new_val = src_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      pc_q       <= '0;
      addr_q     <= '0;
      src_q      <= '0;
      src_zero_q <= 1'b0;
      old_q      <= '0;
      wdata_q    <= '0;
      redir_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      src_q      <= src_d;
      src_zero_q <= src_zero_d;
      old_q      <= old_d;
      wdata_q    <= wdata_d;
      redir_pc_q <= redir_pc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    pc_d       = pc_q;
    addr_d     = addr_q;
    src_d      = src_q;
    src_zero_d = src_zero_q;
    old_d      = old_q;
    wdata_d    = wdata_q;
    redir_pc_d = redir_pc_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d       = in_op;
          pc_d       = in_pc;
          src_d      = in_src;
          src_zero_d = in_src_zero;
          case (in_op)
            OP_CSRRW, OP_CSRRS, OP_CSRRC: begin
              // Only CSR ops move the CSR address so it keeps pointing at the
              // last accessed register otherwise.
              addr_d  = in_csr_addr;
              state_d = S_READ;
            end
            OP_ECALL: state_d = S_TRAP;
            OP_MRET: begin
              redir_pc_d = csr_mepc_i;
              state_d    = S_RESP;
            end
            default: state_d = S_RESP;
          endcase
        end
      end
      S_READ: begin
        // Write data is registered here so csr_wdata_o stays put after the write.
        old_d = csr_rdata_i;
        if (wr_en) begin
          wdata_d = new_val;
        end
        state_d = S_WRITE;
      end
      S_WRITE: state_d = S_RESP;
      S_TRAP: begin
        redir_pc_d = csr_mtvec_i;
        state_d    = S_RESP;
      end
      S_RESP: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are masked during reset so a write in flight is squashed in the
  // very cycle reset is asserted.
  assign run = !reset;

  always_comb begin
    in_ready     = run && (state_q == S_IDLE);
    csr_addr_o   = addr_q;
    csr_wdata_o  = wdata_q;
    csr_type_o   = '0;
    csr_mepc_o   = '0;
    csr_mcause_o = '0;
    out_valid    = 1'b0;
    out_rd_data  = '0;
    out_rd_wen   = 1'b0;
    redirect_en  = 1'b0;
    redirect_pc  = '0;
    if (run) begin
      case (state_q)
        S_WRITE: begin
          if (wr_en) begin
            csr_type_o = TYPE_WRITE;
          end
        end
        S_TRAP: begin
          csr_type_o   = TYPE_ECALL;
          csr_mepc_o   = pc_q;
          csr_mcause_o = ECALL_CAUSE;
        end
        S_RESP: begin
          out_valid = 1'b1;
          if (is_csr_op) begin
            out_rd_data = old_q;
            out_rd_wen  = 1'b1;
          end
          if (is_redir_op) begin
            redirect_en = 1'b1;
            redirect_pc = redir_pc_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
module tb_csr_trap_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = '0;
  logic [31:0] in_pc = '0;
  logic [11:0] in_csr_addr = '0;
  logic [31:0] in_src = '0;
  logic        in_src_zero = 1'b0;
  logic [11:0] csr_addr_o;
  logic [31:0] csr_wdata_o;
  logic [2:0]  csr_type_o;
  logic [31:0] csr_mepc_o;
  logic [31:0] csr_mcause_o;
  logic [31:0] csr_rdata_i;
  logic [31:0] mtvec_v = 32'h8000_1000;
  logic [31:0] mepc_v  = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_rd_data;
  logic        out_rd_wen;
  logic        redirect_en;
  logic [31:0] redirect_pc;

  int n_vec  = 0;
  int n_miss = 0;

  // Tiny CSR file: only the registers the vectors touch.
  logic [31:0] r300 = 32'h0000_1800;
  logic [31:0] r305 = 32'h0000_0000;
  int          wr_cnt = 0;

  csr_trap_ctrl #(
    .DATA_WIDTH (32),
    .TYPE_WRITE (3'b001),
    .TYPE_ECALL (3'b110),
    .ECALL_CAUSE(32'd11)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_pc       (in_pc),
    .in_csr_addr (in_csr_addr),
    .in_src      (in_src),
    .in_src_zero (in_src_zero),
    .csr_addr_o  (csr_addr_o),
    .csr_wdata_o (csr_wdata_o),
    .csr_type_o  (csr_type_o),
    .csr_mepc_o  (csr_mepc_o),
    .csr_mcause_o(csr_mcause_o),
    .csr_rdata_i (csr_rdata_i),
    .csr_mtvec_i (mtvec_v),
    .csr_mepc_i  (mepc_v),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_rd_data (out_rd_data),
    .out_rd_wen  (out_rd_wen),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc)
  );

  always #5 clock = ~clock;

  always_comb begin
    case (csr_addr_o)
      12'h300: csr_rdata_i = r300;
      12'h305: csr_rdata_i = r305;
      12'hF11: csr_rdata_i = 32'h7973_7978;
      default: csr_rdata_i = 32'h0;
    endcase
  end

  // Writes land mid-cycle, away from the DUT's sampling edge.
  always @(negedge clock) begin
    if (csr_type_o != 3'b000) begin
      wr_cnt = wr_cnt + 1;
    end
    if (csr_type_o == 3'b001) begin
      case (csr_addr_o)
        12'h300: r300 = csr_wdata_o;
        12'h305: r305 = csr_wdata_o;
        default: ;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (got !== exp) begin
      n_miss = n_miss + 1;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic accept();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("acc_valid", 32'(out_valid), 32'd0);
    chk("acc_ready", 32'(in_ready), 32'd1);
  endtask

  // Full CSR instruction: handshake, READ, WRITE, RESP, accept.
  task automatic csr_op(input logic [2:0] op, input logic [11:0] addr, input logic [31:0] src,
                        input logic zero, input logic exp_wr, input logic [31:0] exp_wdata,
                        input logic [31:0] exp_old);
    int wc;
    in_valid = 1'b1; in_op = op; in_csr_addr = addr; in_src = src; in_src_zero = zero;
    chk("idle_ready", 32'(in_ready), 32'd1);
    tick();
    wc = wr_cnt;
    in_valid = 1'b0; in_src = ~src; in_csr_addr = 12'hABC; in_src_zero = ~zero;
    chk("rd_addr", 32'(csr_addr_o), 32'(addr));
    chk("rd_type", 32'(csr_type_o), 32'd0);
    chk("rd_busy", 32'(in_ready), 32'd0);
    chk("rd_valid", 32'(out_valid), 32'd0);
    tick();
    chk("wr_type", 32'(csr_type_o), exp_wr ? 32'd1 : 32'd0);
    chk("wr_wdata", exp_wr ? csr_wdata_o : exp_wdata, exp_wdata);
    chk("wr_valid", 32'(out_valid), 32'd0);
    tick();
    chk("rsp_valid", 32'(out_valid), 32'd1);
    chk("rsp_rd", out_rd_data, exp_old);
    chk("rsp_wen", 32'(out_rd_wen), 32'd1);
    chk("rsp_redir", 32'(redirect_en), 32'd0);
    chk("rsp_type", 32'(csr_type_o), 32'd0);
    chk("wr_count", 32'(wr_cnt - wc), exp_wr ? 32'd1 : 32'd0);
    accept();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) tick();
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_type", 32'(csr_type_o), 32'd0);
    chk("rst_addr", 32'(csr_addr_o), 32'd0);
    chk("rst_wdata", csr_wdata_o, 32'd0);
    reset = 1'b0;
    #1;
    chk("rst_rel_ready", 32'(in_ready), 32'd1);

    // 1. CSRRW mtvec
    csr_op(3'b001, 12'h305, 32'h8000_0100, 1'b0, 1'b1, 32'h8000_0100, 32'h0);
    // 2. CSRRS then CSRRC on mstatus
    csr_op(3'b010, 12'h300, 32'h0000_0008, 1'b0, 1'b1, 32'h0000_1808, 32'h0000_1800);
    csr_op(3'b011, 12'h300, 32'h0000_1000, 1'b0, 1'b1, 32'h0000_0808, 32'h0000_1808);
    // 3. CSRRS with zero source: read only
    csr_op(3'b010, 12'hF11, 32'h0, 1'b1, 1'b0, 32'h0000_0808, 32'h7973_7978);
    chk("f11_wdata_held", csr_wdata_o, 32'h0000_0808);

    // 4. ECALL
    in_valid = 1'b1; in_op = 3'b100; in_pc = 32'h8000_0040;
    tick();
    in_valid = 1'b0; in_pc = 32'h0;
    chk("trap_type", 32'(csr_type_o), 32'd6);
    chk("trap_mepc", csr_mepc_o, 32'h8000_0040);
    chk("trap_mcause", csr_mcause_o, 32'd11);
    chk("trap_valid", 32'(out_valid), 32'd0);
    tick();
    mtvec_v = 32'hDEAD_0000;
    #1;
    chk("ecall_valid", 32'(out_valid), 32'd1);
    chk("ecall_redir", 32'(redirect_en), 32'd1);
    chk("ecall_pc", redirect_pc, 32'h8000_1000);
    chk("ecall_wen", 32'(out_rd_wen), 32'd0);
    chk("ecall_rd", out_rd_data, 32'd0);
    chk("ecall_type", 32'(csr_type_o), 32'd0);
    accept();

    // 5. MRET with back-pressure
    mepc_v = 32'h8000_0044;
    in_valid = 1'b1; in_op = 3'b101;
    tick();
    in_valid = 1'b0;
    mepc_v = 32'h1234_5678;
    for (int i = 0; i < 5; i++) begin
      chk("mret_valid", 32'(out_valid), 32'd1);
      chk("mret_pc", redirect_pc, 32'h8000_0044);
      chk("mret_redir", 32'(redirect_en), 32'd1);
      chk("mret_busy", 32'(in_ready), 32'd0);
      tick();
    end
    accept();

    // Illegal opcode: straight to an empty response
    in_valid = 1'b1; in_op = 3'b111;
    tick();
    in_valid = 1'b0;
    chk("ill_valid", 32'(out_valid), 32'd1);
    chk("ill_redir", 32'(redirect_en), 32'd0);
    chk("ill_pc", redirect_pc, 32'd0);
    chk("ill_wen", 32'(out_rd_wen), 32'd0);
    chk("ill_rd", out_rd_data, 32'd0);
    accept();

    // 6. Reset in the middle of a write
    in_valid = 1'b1; in_op = 3'b001; in_csr_addr = 12'h300; in_src = 32'hDEAD_BEEF; in_src_zero = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    chk("mid_wr_type", 32'(csr_type_o), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_type", 32'(csr_type_o), 32'd0);
    tick();
    chk("mid_rst_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_addr", 32'(csr_addr_o), 32'd0);
    chk("mid_rst_wdata", csr_wdata_o, 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", 32'(in_ready), 32'd1);
    chk("no_wr_300", r300, 32'h0000_0808);
    csr_op(3'b001, 12'h305, 32'h8000_1000, 1'b0, 1'b1, 32'h8000_1000, 32'h8000_0100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
